// File: rtl/decode_ctrl_stage_if.sv
// D-stage to E-stage control bundle for the RV32I decode control stage.
// The driver of InstrD/ValidD/FlushE uses master; the decode stage uses slave.
interface decode_ctrl_stage_if;
    logic [31:0] InstrD;
    logic        ValidD;
    logic        FlushE;
    logic [2:0]  ImmSrcD;
    logic        StallD;
    logic        ValidE;
    logic        RegWriteE;
    logic        ALUSrcE;
    logic        MemWriteE;
    logic [1:0]  ResultSrcE;
    logic        BranchE;
    logic        JumpE;
    logic [1:0]  ALUOpE;
    logic        MulDivE;
    logic        IllegalE;

    modport master (
        output InstrD, ValidD, FlushE,
        input  ImmSrcD, StallD, ValidE, RegWriteE, ALUSrcE, MemWriteE,
               ResultSrcE, BranchE, JumpE, ALUOpE, MulDivE, IllegalE
    );

    modport slave (
        input  InstrD, ValidD, FlushE,
        output ImmSrcD, StallD, ValidE, RegWriteE, ALUSrcE, MemWriteE,
               ResultSrcE, BranchE, JumpE, ALUOpE, MulDivE, IllegalE
    );
endinterface

// File: rtl/decode_ctrl_stage.sv
// Main-decode stage: combinational ImmSrcD, registered ID/EX control bundle,
// and an occupancy counter that holds E and stalls F/D for multi-cycle MUL/DIV.
module decode_ctrl_stage #(
    parameter int ENABLE_M   = 1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8
) (
    input logic             clk,
    input logic             rst,
    decode_ctrl_stage_if.slave bus
);

    typedef struct packed {
        logic       regWrite;
        logic       aluSrc;
        logic       memWrite;
        logic [1:0] resultSrc;
        logic       branch;
        logic       jump;
        logic [1:0] aluOp;
        logic       mulDiv;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    logic [6:0] opcode_s;
    logic [6:0] funct7_s;
    logic [3:0] loadCnt_s;
    logic       unusedInstr_s;
    ctrl_t      dec_s;
    logic [2:0] immSrc_s;

    ctrl_t      eCtrl_r;
    logic       validE_r;
    logic [3:0] cnt_r;
    state_t     state_r;

    assign opcode_s      = bus.InstrD[6:0];
    assign funct7_s      = bus.InstrD[31:25];
    assign loadCnt_s     = bus.InstrD[14] ? DIV_LOAD : MUL_LOAD;
    assign unusedInstr_s = ^{bus.InstrD[24:15], bus.InstrD[13:7]};

    // Opcode table: control bundle for E plus the immediate select for D.
    always_comb begin
        dec_s    = '0;
        immSrc_s = 3'b000;
        case (opcode_s)
            7'b0110011: begin
                if (funct7_s == 7'b0000001) begin
                    if (ENABLE_M != 0) begin
                        dec_s.regWrite = 1'b1;
                        dec_s.aluOp    = 2'b11;
                        dec_s.mulDiv   = 1'b1;
                    end else begin
                        dec_s.illegal  = 1'b1;
                    end
                end else begin
                    dec_s.regWrite = 1'b1;
                    dec_s.aluOp    = 2'b10;
                end
            end
            7'b0010011: begin
                dec_s.regWrite = 1'b1;
                dec_s.aluSrc   = 1'b1;
                dec_s.aluOp    = 2'b10;
            end
            7'b0000011: begin
                dec_s.regWrite  = 1'b1;
                dec_s.aluSrc    = 1'b1;
                dec_s.resultSrc = 2'b01;
            end
            7'b0100011: begin
                dec_s.aluSrc   = 1'b1;
                dec_s.memWrite = 1'b1;
                immSrc_s       = 3'b001;
            end
            7'b1100011: begin
                dec_s.branch = 1'b1;
                dec_s.aluOp  = 2'b01;
                immSrc_s     = 3'b010;
            end
            7'b1101111: begin
                dec_s.regWrite  = 1'b1;
                dec_s.resultSrc = 2'b10;
                dec_s.jump      = 1'b1;
                immSrc_s        = 3'b011;
            end
            7'b1100111: begin
                dec_s.regWrite  = 1'b1;
                dec_s.aluSrc    = 1'b1;
                dec_s.resultSrc = 2'b10;
                dec_s.jump      = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                dec_s.regWrite = 1'b1;
                dec_s.aluSrc   = 1'b1;
                immSrc_s       = 3'b100;
            end
            default: begin
                dec_s.illegal = 1'b1;
            end
        endcase
    end

    // ID/EX register and occupancy FSM; a busy E holds its contents until cnt drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eCtrl_r  <= '0;
            validE_r <= 1'b0;
            cnt_r    <= 4'd0;
            state_r  <= IDLE;
        end else if (bus.FlushE) begin
            eCtrl_r  <= '0;
            validE_r <= 1'b0;
            cnt_r    <= 4'd0;
            state_r  <= IDLE;
        end else if (state_r == BUSY) begin
            cnt_r    <= cnt_r - 4'd1;
            state_r  <= (cnt_r == 4'd1) ? IDLE : BUSY;
        end else if (!bus.ValidD) begin
            eCtrl_r  <= '0;
            validE_r <= 1'b0;
            cnt_r    <= 4'd0;
            state_r  <= IDLE;
        end else begin
            eCtrl_r  <= dec_s;
            validE_r <= 1'b1;
            if (dec_s.mulDiv && (loadCnt_s != 4'd0)) begin
                cnt_r   <= loadCnt_s;
                state_r <= BUSY;
            end else begin
                cnt_r   <= 4'd0;
                state_r <= IDLE;
            end
        end
    end

    assign bus.ImmSrcD    = immSrc_s;
    assign bus.StallD     = (state_r == BUSY);
    assign bus.ValidE     = validE_r;
    assign bus.RegWriteE  = eCtrl_r.regWrite;
    assign bus.ALUSrcE    = eCtrl_r.aluSrc;
    assign bus.MemWriteE  = eCtrl_r.memWrite;
    assign bus.ResultSrcE = eCtrl_r.resultSrc;
    assign bus.BranchE    = eCtrl_r.branch;
    assign bus.JumpE      = eCtrl_r.jump;
    assign bus.ALUOpE     = eCtrl_r.aluOp;
    assign bus.MulDivE    = eCtrl_r.mulDiv;
    assign bus.IllegalE   = eCtrl_r.illegal;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: opcode table vectors plus hand-written
// multi-cycle MUL/DIV, flush, reset and ENABLE_M=0 sequences.
module tb_decode_ctrl_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instrD;
    logic        validD;
    logic        flushE;
    int          nRun;
    int          nFail;

    decode_ctrl_stage_if busM ();
    decode_ctrl_stage_if busNoM ();

    assign busM.InstrD   = instrD;
    assign busM.ValidD   = validD;
    assign busM.FlushE   = flushE;
    assign busNoM.InstrD = instrD;
    assign busNoM.ValidD = validD;
    assign busNoM.FlushE = flushE;

    decode_ctrl_stage #(.ENABLE_M(1), .MUL_CYCLES(2), .DIV_CYCLES(8)) dutM (
        .clk(clk), .rst(rst), .bus(busM.slave)
    );

    decode_ctrl_stage #(.ENABLE_M(0), .MUL_CYCLES(2), .DIV_CYCLES(8)) dutNoM (
        .clk(clk), .rst(rst), .bus(busNoM.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected E bundle: {ValidE,RegWrite,ALUSrc,MemWrite,ResultSrc,Branch,Jump,ALUOp,MulDiv,Illegal}
    function automatic logic [11:0] mk(input logic v, input logic rw, input logic as,
                                       input logic mw, input logic [1:0] rs, input logic b,
                                       input logic j, input logic [1:0] op, input logic md,
                                       input logic il);
        return {v, rw, as, mw, rs, b, j, op, md, il};
    endfunction

    function automatic logic [11:0] obsM();
        return {busM.ValidE, busM.RegWriteE, busM.ALUSrcE, busM.MemWriteE, busM.ResultSrcE,
                busM.BranchE, busM.JumpE, busM.ALUOpE, busM.MulDivE, busM.IllegalE};
    endfunction

    function automatic logic [11:0] obsNoM();
        return {busNoM.ValidE, busNoM.RegWriteE, busNoM.ALUSrcE, busNoM.MemWriteE,
                busNoM.ResultSrcE, busNoM.BranchE, busNoM.JumpE, busNoM.ALUOpE,
                busNoM.MulDivE, busNoM.IllegalE};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nRun++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        valid;
        logic        flush;
        logic [2:0]  expImm;
        logic [11:0] expE;
    } vec_t;

    vec_t vecs[14];

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] MUL  = 32'h022081B3;
    localparam logic [31:0] DIV  = 32'h0220C1B3;
    localparam logic [11:0] BUBBLE = 12'h000;

    initial begin
        nRun  = 0;
        nFail = 0;
        rst    = 1'b1;
        instrD = 32'h0;
        validD = 1'b0;
        flushE = 1'b0;

        vecs[0]  = '{"addi",     ADDI,         1'b1, 1'b0, 3'b000, mk(1,1,1,0,2'b00,0,0,2'b10,0,0)};
        vecs[1]  = '{"add",      32'h003100B3, 1'b1, 1'b0, 3'b000, mk(1,1,0,0,2'b00,0,0,2'b10,0,0)};
        vecs[2]  = '{"lw",       32'h0000A103, 1'b1, 1'b0, 3'b000, mk(1,1,1,0,2'b01,0,0,2'b00,0,0)};
        vecs[3]  = '{"sw",       32'h0020A023, 1'b1, 1'b0, 3'b001, mk(1,0,1,1,2'b00,0,0,2'b00,0,0)};
        vecs[4]  = '{"sw_flush", 32'h0020A023, 1'b1, 1'b1, 3'b001, BUBBLE};
        vecs[5]  = '{"sw_noval", 32'h0020A023, 1'b0, 1'b0, 3'b001, BUBBLE};
        vecs[6]  = '{"beq",      32'h00208463, 1'b1, 1'b0, 3'b010, mk(1,0,0,0,2'b00,1,0,2'b01,0,0)};
        vecs[7]  = '{"jal",      32'h008000EF, 1'b1, 1'b0, 3'b011, mk(1,1,0,0,2'b10,0,1,2'b00,0,0)};
        vecs[8]  = '{"jalr",     32'h000080E7, 1'b1, 1'b0, 3'b000, mk(1,1,1,0,2'b10,0,1,2'b00,0,0)};
        vecs[9]  = '{"lui",      32'h123450B7, 1'b1, 1'b0, 3'b100, mk(1,1,1,0,2'b00,0,0,2'b00,0,0)};
        vecs[10] = '{"auipc",    32'h00001097, 1'b1, 1'b0, 3'b100, mk(1,1,1,0,2'b00,0,0,2'b00,0,0)};
        vecs[11] = '{"illegal",  32'hFFFFFFFF, 1'b1, 1'b0, 3'b000, mk(1,0,0,0,2'b00,0,0,2'b00,0,1)};
        vecs[12] = '{"sub",      32'h40208033, 1'b1, 1'b0, 3'b000, mk(1,1,0,0,2'b00,0,0,2'b10,0,0)};
        vecs[13] = '{"noval_fl", 32'h00208463, 1'b0, 1'b1, 3'b010, BUBBLE};

        #2;
        chk("reset_E", {20'h0, obsM()}, 32'h0);
        chk("reset_stall", {31'h0, busM.StallD}, 32'h0);
        tick();
        rst = 1'b0;

        // Single-cycle opcode table
        for (int i = 0; i < 14; i++) begin
            instrD = vecs[i].instr;
            validD = vecs[i].valid;
            flushE = vecs[i].flush;
            #1;
            chk({vecs[i].name, "_imm"}, {29'h0, busM.ImmSrcD}, {29'h0, vecs[i].expImm});
            tick();
            chk({vecs[i].name, "_E"}, {20'h0, obsM()}, {20'h0, vecs[i].expE});
            chk({vecs[i].name, "_stall"}, {31'h0, busM.StallD}, 32'h0);
        end
        flushE = 1'b0;

        // MUL with default occupancy 2; ENABLE_M=0 instance sees it as illegal
        instrD = MUL; validD = 1'b1;
        tick();
        chk("mul_E1", {20'h0, obsM()}, {20'h0, mk(1,1,0,0,2'b00,0,0,2'b11,1,0)});
        chk("mul_stall1", {31'h0, busM.StallD}, 32'h1);
        chk("noM_illegal", {20'h0, obsNoM()}, {20'h0, mk(1,0,0,0,2'b00,0,0,2'b00,0,1)});
        chk("noM_stall", {31'h0, busNoM.StallD}, 32'h0);
        instrD = ADDI;
        tick();
        chk("mul_E2_hold", {20'h0, obsM()}, {20'h0, mk(1,1,0,0,2'b00,0,0,2'b11,1,0)});
        chk("mul_stall2", {31'h0, busM.StallD}, 32'h0);
        chk("noM_next_addi", {20'h0, obsNoM()}, {20'h0, mk(1,1,1,0,2'b00,0,0,2'b10,0,0)});
        tick();
        chk("mul_then_addi", {20'h0, obsM()}, {20'h0, mk(1,1,1,0,2'b00,0,0,2'b10,0,0)});

        // DIV with FlushE on its third cycle in E
        instrD = DIV; validD = 1'b1;
        tick();
        chk("div_E1", {20'h0, obsM()}, {20'h0, mk(1,1,0,0,2'b00,0,0,2'b11,1,0)});
        chk("div_stall1", {31'h0, busM.StallD}, 32'h1);
        validD = 1'b0;
        tick();
        tick();
        chk("div_E3_hold", {20'h0, obsM()}, {20'h0, mk(1,1,0,0,2'b00,0,0,2'b11,1,0)});
        chk("div_stall3", {31'h0, busM.StallD}, 32'h1);
        flushE = 1'b1;
        tick();
        flushE = 1'b0;
        chk("div_flush_E", {20'h0, obsM()}, {20'h0, BUBBLE});
        chk("div_flush_stall", {31'h0, busM.StallD}, 32'h0);

        // FlushE while MUL sits in D: bubble and no occupancy
        instrD = MUL; validD = 1'b1; flushE = 1'b1;
        tick();
        flushE = 1'b0; validD = 1'b0;
        chk("flushD_E", {20'h0, obsM()}, {20'h0, BUBBLE});
        chk("flushD_stall", {31'h0, busM.StallD}, 32'h0);
        tick();
        chk("flushD_stall2", {31'h0, busM.StallD}, 32'h0);

        // Back-to-back MULs: second loads on the edge after cnt reaches 0
        instrD = MUL; validD = 1'b1;
        tick();
        chk("b2b_stall1", {31'h0, busM.StallD}, 32'h1);
        tick();
        chk("b2b_stall2", {31'h0, busM.StallD}, 32'h0);
        tick();
        chk("b2b_second_E", {20'h0, obsM()}, {20'h0, mk(1,1,0,0,2'b00,0,0,2'b11,1,0)});
        chk("b2b_stall3", {31'h0, busM.StallD}, 32'h1);
        tick();

        // Reset mid-DIV at cnt=5, then addi one cycle after release
        instrD = DIV; validD = 1'b1;
        tick();
        instrD = ADDI;
        tick();
        tick();
        chk("rdiv_stall_before", {31'h0, busM.StallD}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rdiv_async_E", {20'h0, obsM()}, 32'h0);
        chk("rdiv_async_stall", {31'h0, busM.StallD}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("rdiv_addi_E", {20'h0, obsM()}, {20'h0, mk(1,1,1,0,2'b00,0,0,2'b10,0,0)});
        chk("rdiv_addi_stall", {31'h0, busM.StallD}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end

endmodule
